// File: rtl/fp_pkg.sv
// Shared types and constants for the FP32 align/add stage.
package fp_pkg;

    localparam int WIDTH     = 32;
    localparam int MANT_BITS = 23;
    localparam int EXP_BITS  = 8;
    localparam int REM_MAX   = 25;

    typedef struct packed {
        logic                 sign;
        logic [EXP_BITS-1:0]  exp;
        logic [MANT_BITS-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} align_state_t;

    typedef logic [MANT_BITS:0]   mant_t;      // {hidden, fraction}
    typedef logic [MANT_BITS+1:0] sum_mant_t;  // {carry, hidden, fraction}
    typedef logic [4:0]           rem_t;

    // The hidden bit is implied by any non-zero exponent field.
    function automatic mant_t unpack_mant(input fp32_t x);
        return {|x.exp, x.frac};
    endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// One alignment step: shifts the smaller mantissa right by at most SHIFT_STEP.
// With FP_ALIGN_STICKY_EN defined, shifted-out bits are ORed into bit 0.
module fp_align_shifter
    import fp_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic [MANT_BITS:0] mant_in,
    input  logic [4:0]         rem,
    output logic [MANT_BITS:0] mant_out,
    output logic [4:0]         rem_next
);

    localparam rem_t STEP = rem_t'(SHIFT_STEP);

    rem_t step;
`ifdef FP_ALIGN_STICKY_EN
    mant_t lost_mask;
`endif

    always_comb begin
        step     = (rem > STEP) ? STEP : rem;
        mant_out = mant_in >> step;
        rem_next = rem - step;
`ifdef FP_ALIGN_STICKY_EN
        lost_mask   = (mant_t'(1) << step) - mant_t'(1);
        mant_out[0] = mant_out[0] | (|(mant_in & lost_mask));
`endif
    end

endmodule

// File: rtl/fp_align_add.sv
// Multi-cycle FP32 exponent alignment and signed-magnitude mantissa add/sub.
// Optional sticky alignment under FP_ALIGN_STICKY_EN.
module fp_align_add
    import fp_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MANT_BITS+1:0] result_mant,
    output logic [EXP_BITS-1:0]  exp_result,
    output logic                 sign_result
);

    align_state_t        state_q, state_d;
    mant_t               mant_l_q, mant_l_d;
    mant_t               mant_s_q, mant_s_d;
    logic [EXP_BITS-1:0] exp_l_q, exp_l_d;
    logic                sign_l_q, sign_l_d;
    logic                sign_s_q, sign_s_d;
    rem_t                rem_q, rem_d;
    sum_mant_t           res_mant_q, res_mant_d;
    logic [EXP_BITS-1:0] res_exp_q, res_exp_d;
    logic                res_sign_q, res_sign_d;

    fp32_t               a_f, b_f;
    logic [EXP_BITS-1:0] exp_diff;
    mant_t               shift_mant;
    rem_t                shift_rem;

    assign a_f = a;
    assign b_f = b;

    fp_align_shifter #(.SHIFT_STEP(SHIFT_STEP)) u_shifter (
        .mant_in  (mant_s_q),
        .rem      (rem_q),
        .mant_out (shift_mant),
        .rem_next (shift_rem)
    );

    always_comb begin
        // NOTE: every signal gets its hold value first so no path infers a latch.
        state_d    = state_q;
        mant_l_d   = mant_l_q;
        mant_s_d   = mant_s_q;
        exp_l_d    = exp_l_q;
        sign_l_d   = sign_l_q;
        sign_s_d   = sign_s_q;
        rem_d      = rem_q;
        res_mant_d = res_mant_q;
        res_exp_d  = res_exp_q;
        res_sign_d = res_sign_q;
        exp_diff   = '0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Equal exponents keep A as the larger-exponent operand.
                    if (b_f.exp > a_f.exp) begin
                        mant_l_d = unpack_mant(b_f);
                        sign_l_d = b_f.sign ^ op;
                        exp_l_d  = b_f.exp;
                        mant_s_d = unpack_mant(a_f);
                        sign_s_d = a_f.sign;
                        exp_diff = b_f.exp - a_f.exp;
                    end else begin
                        mant_l_d = unpack_mant(a_f);
                        sign_l_d = a_f.sign;
                        exp_l_d  = a_f.exp;
                        mant_s_d = unpack_mant(b_f);
                        sign_s_d = b_f.sign ^ op;
                        exp_diff = a_f.exp - b_f.exp;
                    end
                    rem_d   = (exp_diff > EXP_BITS'(REM_MAX)) ? rem_t'(REM_MAX) : exp_diff[4:0];
                    state_d = (rem_d != '0) ? ALIGN : ADD;
                end
            end
            ALIGN: begin
                mant_s_d = shift_mant;
                rem_d    = shift_rem;
                if (shift_rem == '0) state_d = ADD;
            end
            ADD: begin
                res_exp_d = exp_l_q;
                if (sign_l_q == sign_s_q) begin
                    res_mant_d = sum_mant_t'(mant_l_q) + sum_mant_t'(mant_s_q);
                    res_sign_d = sign_l_q;
                end else if (mant_l_q > mant_s_q) begin
                    res_mant_d = sum_mant_t'(mant_l_q - mant_s_q);
                    res_sign_d = sign_l_q;
                end else if (mant_s_q > mant_l_q) begin
                    res_mant_d = sum_mant_t'(mant_s_q - mant_l_q);
                    res_sign_d = sign_s_q;
                end else begin
                    res_mant_d = '0;
                    res_sign_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mant_l_q   <= '0;
            mant_s_q   <= '0;
            exp_l_q    <= '0;
            sign_l_q   <= 1'b0;
            sign_s_q   <= 1'b0;
            rem_q      <= '0;
            res_mant_q <= '0;
            res_exp_q  <= '0;
            res_sign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mant_l_q   <= mant_l_d;
            mant_s_q   <= mant_s_d;
            exp_l_q    <= exp_l_d;
            sign_l_q   <= sign_l_d;
            sign_s_q   <= sign_s_d;
            rem_q      <= rem_d;
            res_mant_q <= res_mant_d;
            res_exp_q  <= res_exp_d;
            res_sign_q <= res_sign_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign result_mant = res_mant_q;
    assign exp_result  = res_exp_q;
    assign sign_result = res_sign_q;

endmodule

// File: tb/tb_fp_align_add.sv
// Self-checking bench for fp_align_add: directed vectors, random operands
// against an arithmetic reference model, backpressure and mid-op reset.
module tb_fp_align_add;

    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        op;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] result_mant;
    logic [7:0]  exp_result;
    logic        sign_result;

    int n_checks = 0;
    int n_fail   = 0;

    fp_align_add #(.SHIFT_STEP(STEP)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .op          (op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result_mant (result_mant),
        .exp_result  (exp_result),
        .sign_result (sign_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: whole alignment done as one shift of min(d,25), then signed arithmetic.
    task automatic model(input logic [31:0] xa, input logic [31:0] xb, input logic xop,
                         output logic [24:0] m, output logic [7:0] e,
                         output logic s, output int lat);
        int ea, eb, el, es, ml, ms, sh, r;
        logic sa, sbe, sl, ss;
        ea = int'(xa[30:23]);
        eb = int'(xb[30:23]);
        sa = xa[31];
        sbe = xb[31] ^ xop;
        if (eb > ea) begin
            el = eb; es = ea; sl = sbe; ss = sa;
            ml = ((eb != 0) ? 32'h800000 : 0) + int'(xb[22:0]);
            ms = ((ea != 0) ? 32'h800000 : 0) + int'(xa[22:0]);
        end else begin
            el = ea; es = eb; sl = sa; ss = sbe;
            ml = ((ea != 0) ? 32'h800000 : 0) + int'(xa[22:0]);
            ms = ((eb != 0) ? 32'h800000 : 0) + int'(xb[22:0]);
        end
        sh = (el - es > 25) ? 25 : el - es;
`ifdef FP_ALIGN_STICKY_EN
        if ((ms % (1 << sh)) != 0) ms = (ms >> sh) | 1;
        else ms = ms >> sh;
`else
        ms = ms >> sh;
`endif
        if (sl == ss) begin
            r = ml + ms; s = sl;
        end else begin
            r = ml - ms;
            if (r > 0) s = sl;
            else if (r < 0) begin s = ss; r = -r; end
            else s = 1'b0;
        end
        m = 25'(r);
        e = 8'(el);
        lat = (sh + STEP - 1) / STEP + 1;
    endtask

    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic xop,
                          input int stall, input string tag);
        logic [24:0] em;
        logic [7:0]  ee;
        logic        es;
        int          elat, lat;
        model(xa, xb, xop, em, ee, es, elat);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = xa; b = xb; op = xop; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_mant"}, 32'(result_mant), 32'(em));
        check({tag, "_exp"}, 32'(exp_result), 32'(ee));
        check({tag, "_sign"}, 32'(sign_result), 32'(es));
        repeat (stall) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_mant"}, 32'(result_mant), 32'(em));
            check({tag, "_hold_exp"}, 32'(exp_result), 32'(ee));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
        check({tag, "_persist"}, 32'(result_mant), 32'(em));
    endtask

    initial begin
        logic [31:0] ra, rb;
        int ewant;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mant", 32'(result_mant), 32'd0);
        check("rst_exp", 32'(exp_result), 32'd0);
        check("rst_sign", 32'(sign_result), 32'd0);
        @(negedge clk) rst = 1'b0;

        run_op(32'h3F800000, 32'h3F800000, 1'b0, 0, "equal_add");
        check("equal_add_const", 32'(result_mant), 32'h1000000);
        run_op(32'h3F800000, 32'h3F800000, 1'b1, 0, "cancel");
        check("cancel_const", 32'(result_mant), 32'h0);
        run_op(32'h3F800000, 32'h3F000000, 1'b0, 0, "align1");
        check("align1_const", 32'(result_mant), 32'h0C00000);
        run_op(32'h40000000, 32'h40400000, 1'b1, 0, "negative");
        check("negative_sign", 32'(sign_result), 32'd1);
        check("negative_exp", 32'(exp_result), 32'h80);
        run_op(32'h3F800000, 32'h33800000, 1'b0, 5, "large_shift");
`ifdef FP_ALIGN_STICKY_EN
        check("large_shift_const", 32'(result_mant), 32'h0800001);
`else
        check("large_shift_const", 32'(result_mant), 32'h0800000);
`endif

        // Reset while the large-shift operation is in ALIGN.
        @(negedge clk);
        a = 32'h3F800000; b = 32'h33800000; op = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_mant", 32'(result_mant), 32'd0);
        @(negedge clk) rst = 1'b0;
        run_op(32'h40000000, 32'h40400000, 1'b0, 1, "after_rst");

        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) rb[30:23] = ra[30:23];
            else if (i % 3 == 1) begin
                ewant = int'(ra[30:23]) + int'($urandom_range(0, 30)) - 15;
                if (ewant < 0) ewant = 0;
                if (ewant > 255) ewant = 255;
                rb[30:23] = 8'(ewant);
            end
            run_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
